// File: rtl/wb_router_pkg.sv
// Shared types and helpers for the Wishbone single-master router.
package wb_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Read data returned to the master on a decode miss or timeout.
    localparam int ERR_RDATA = 0;

    // Index width for n slaves; never zero so a single-slave build still has a select register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational priority decoder: matches an address tag against per-slave tags, lowest index wins.
module wb_addr_decode
    import wb_router_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_BITS  = 3,
    parameter int IDX_W      = idx_w(NUM_SLAVES)
) (
    input  logic [ADDR_BITS-1:0]                 tag_i,
    input  logic [NUM_SLAVES-1:0][ADDR_BITS-1:0] s_address_i,
    output logic                                 hit_o,
    output logic [IDX_W-1:0]                     idx_o
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (tag_i == s_address_i[i]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_router_tmo.sv
// Routes one Wishbone master to NUM_SLAVES slaves by address-MSB tag; ack, err and read data are registered.
// Define WB_ROUTER_TIMEOUT_EN to end a transaction with an error when the slave stays silent TIMEOUT_CYCLES cycles.
module wb_router_tmo
    import wb_router_pkg::*;
#(
    parameter int NUM_SLAVES     = 3,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int ADDR_BITS      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     wb_clk,
    input  logic                                     wb_rst_n,
    input  logic [NUM_SLAVES-1:0][ADDR_BITS-1:0]     s_address,
    input  logic [NUM_SLAVES-1:0][WB_DATA_WIDTH-1:0] s_wb_rdt,
    input  logic [NUM_SLAVES-1:0]                    s_wb_ack,
    output logic [NUM_SLAVES-1:0][WB_DATA_WIDTH-1:0] s_wb_dat,
    output logic [NUM_SLAVES-1:0][WB_DATA_WIDTH-1:0] s_wb_adr,
    output logic [NUM_SLAVES-1:0][WB_DATA_WIDTH/8-1:0] s_wb_sel,
    output logic [NUM_SLAVES-1:0]                    s_wb_we,
    output logic [NUM_SLAVES-1:0]                    s_wb_cyc,
    input  logic [WB_DATA_WIDTH-1:0]                 m_wb_adr,
    input  logic [WB_DATA_WIDTH-1:0]                 m_wb_dat,
    input  logic [WB_DATA_WIDTH/8-1:0]               m_wb_sel,
    input  logic                                     m_wb_we,
    input  logic                                     m_wb_cyc,
    output logic [WB_DATA_WIDTH-1:0]                 m_wb_rdt,
    output logic                                     m_wb_ack,
    output logic                                     m_wb_err
);

    localparam int IDX_W = idx_w(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || (WB_DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wb_router_tmo: illegal parameter combination");
    end

    state_t                   state_q;
    logic [IDX_W-1:0]         sel_idx_q;
    logic                     ack_q;
    logic                     err_q;
    logic [WB_DATA_WIDTH-1:0] rdt_q;

    logic                     hit;
    logic [IDX_W-1:0]         hit_idx;
    logic                     sel_ack;
    logic [WB_DATA_WIDTH-1:0] sel_rdt;

`ifdef WB_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_BITS  (ADDR_BITS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .tag_i       (m_wb_adr[WB_DATA_WIDTH-1 -: ADDR_BITS]),
        .s_address_i (s_address),
        .hit_o       (hit),
        .idx_o       (hit_idx)
    );

    // Only the latched slave sees the request, and only while waiting on it.
    always_comb begin
        s_wb_cyc = '0;
        s_wb_we  = '0;
        s_wb_dat = '0;
        s_wb_adr = '0;
        s_wb_sel = '0;
        sel_ack  = 1'b0;
        sel_rdt  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx_q == IDX_W'(i)) begin
                sel_ack = s_wb_ack[i];
                sel_rdt = s_wb_rdt[i];
                if (state_q == WAIT) begin
                    s_wb_cyc[i] = m_wb_cyc;
                    s_wb_we[i]  = m_wb_we;
                    s_wb_dat[i] = m_wb_dat;
                    s_wb_adr[i] = m_wb_adr;
                    s_wb_sel[i] = m_wb_sel;
                end
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            sel_idx_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdt_q     <= '0;
`ifdef WB_ROUTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_wb_cyc) begin
                        if (hit) begin
                            sel_idx_q <= hit_idx;
`ifdef WB_ROUTER_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                            state_q   <= WAIT;
                        end else begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdt_q   <= WB_DATA_WIDTH'(ERR_RDATA);
                            state_q <= ERR;
                        end
                    end
                end
                WAIT: begin
                    // A dropped cyc means the master abandoned the access; any ack is moot.
                    if (!m_wb_cyc) begin
                        state_q <= IDLE;
                    end else if (sel_ack) begin
                        ack_q   <= 1'b1;
                        rdt_q   <= sel_rdt;
                        state_q <= RESP;
                    end
`ifdef WB_ROUTER_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdt_q   <= WB_DATA_WIDTH'(ERR_RDATA);
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_wb_ack = ack_q;
    assign m_wb_err = err_q;
    assign m_wb_rdt = rdt_q;

endmodule

// File: tb/tb_wb_router_tmo.sv
// Randomized self-checking bench for wb_router_tmo against a transaction-level outcome model.
module tb_wb_router_tmo;
    import wb_router_pkg::*;

    localparam int NS  = 3;
    localparam int DW  = 32;
    localparam int AB  = 3;
    localparam int TMO = 8;
`ifdef WB_ROUTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NS-1:0][AB-1:0]    s_address;
    logic [NS-1:0][DW-1:0]    s_wb_rdt;
    logic [NS-1:0]            s_wb_ack;
    logic [NS-1:0][DW-1:0]    s_wb_dat;
    logic [NS-1:0][DW-1:0]    s_wb_adr;
    logic [NS-1:0][DW/8-1:0]  s_wb_sel;
    logic [NS-1:0]            s_wb_we;
    logic [NS-1:0]            s_wb_cyc;
    logic [DW-1:0]            m_wb_adr;
    logic [DW-1:0]            m_wb_dat;
    logic [DW/8-1:0]          m_wb_sel;
    logic                     m_wb_we;
    logic                     m_wb_cyc;
    logic [DW-1:0]            m_wb_rdt;
    logic                     m_wb_ack;
    logic                     m_wb_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] rdt_model;

    always #5 clk = ~clk;

    wb_router_tmo #(
        .NUM_SLAVES     (NS),
        .WB_DATA_WIDTH  (DW),
        .ADDR_BITS      (AB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk    (clk),
        .wb_rst_n  (rst_n),
        .s_address (s_address),
        .s_wb_rdt  (s_wb_rdt),
        .s_wb_ack  (s_wb_ack),
        .s_wb_dat  (s_wb_dat),
        .s_wb_adr  (s_wb_adr),
        .s_wb_sel  (s_wb_sel),
        .s_wb_we   (s_wb_we),
        .s_wb_cyc  (s_wb_cyc),
        .m_wb_adr  (m_wb_adr),
        .m_wb_dat  (m_wb_dat),
        .m_wb_sel  (m_wb_sel),
        .m_wb_we   (m_wb_we),
        .m_wb_cyc  (m_wb_cyc),
        .m_wb_rdt  (m_wb_rdt),
        .m_wb_ack  (m_wb_ack),
        .m_wb_err  (m_wb_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One master transaction. delay: WAIT cycle (0-based) in which the target acks;
    // abort_at: WAIT cycle in which the master drops cyc (-1 = never);
    // b2b: keep cyc high after the ack so the next call starts in the following IDLE cycle.
    task automatic run_txn(input string name, input logic [DW-1:0] adr, input logic we,
                           input logic [DW-1:0] dat, input logic [DW/8-1:0] sel,
                           input logic [DW-1:0] val, input int delay, input int abort_at,
                           input bit stray, input bit b2b);
        int j;
        int ack_cyc;
        int hi_last;
        int cyc_end;
        int last;
        bit exp_err;
        logic [AB-1:0] tag;
        logic [NS-1:0] exp_cyc;
        j = -1;
        tag = adr[DW-1 -: AB];
        for (int i = 0; i < NS; i++)
            if (j < 0 && s_address[i] == tag) j = i;
        exp_err = 1'b0;
        ack_cyc = -1;
        hi_last = 0;
        if (j < 0) begin
            ack_cyc = 1;
            exp_err = 1'b1;
        end else if (abort_at >= 0 && abort_at <= delay && (!TMO_EN || abort_at <= TMO - 1)) begin
            hi_last = abort_at;
        end else if (!TMO_EN || delay <= TMO - 1) begin
            ack_cyc = 2 + delay;
            hi_last = 1 + delay;
        end else begin
            ack_cyc = 1 + TMO;
            exp_err = 1'b1;
            hi_last = TMO;
        end
        cyc_end = (ack_cyc < 0) ? abort_at : ack_cyc;
        last    = (ack_cyc < 0) ? abort_at + 3 : (b2b ? ack_cyc : ack_cyc + 1);

        for (int c = 0; c <= last; c++) begin
            step();
            m_wb_adr = adr;
            m_wb_dat = dat;
            m_wb_sel = sel;
            m_wb_we  = we;
            m_wb_cyc = (c <= cyc_end);
            for (int i = 0; i < NS; i++) begin
                s_wb_rdt[i] = $urandom;
                s_wb_ack[i] = stray && (i != j) && ($urandom_range(0, 1) == 1);
            end
            if (j >= 0 && ack_cyc >= 0 && !exp_err && c == 1 + delay) begin
                s_wb_ack[j] = 1'b1;
                s_wb_rdt[j] = val;
            end
            #1;
            if (c == ack_cyc) rdt_model = exp_err ? '0 : val;
            exp_cyc = (j >= 0 && c >= 1 && c <= hi_last) ? NS'(1 << j) : '0;
            check($sformatf("%s c%0d cyc", name, c), s_wb_cyc, exp_cyc);
            check($sformatf("%s c%0d ack", name, c), m_wb_ack, (c == ack_cyc));
            check($sformatf("%s c%0d err", name, c), m_wb_err, (c == ack_cyc) && exp_err);
            check($sformatf("%s c%0d rdt", name, c), m_wb_rdt, rdt_model);
            if (exp_cyc != '0) begin
                for (int i = 0; i < NS; i++) begin
                    check($sformatf("%s c%0d adr%0d", name, c, i), s_wb_adr[i], (i == j) ? adr : '0);
                    check($sformatf("%s c%0d dat%0d", name, c, i), s_wb_dat[i], (i == j) ? dat : '0);
                    check($sformatf("%s c%0d sel%0d", name, c, i), s_wb_sel[i], (i == j) ? sel : '0);
                    check($sformatf("%s c%0d we%0d", name, c, i), s_wb_we[i], (i == j) ? we : 1'b0);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        s_address = {3'd2, 3'd1, 3'd0};
        s_wb_rdt  = '0;
        s_wb_ack  = '0;
        m_wb_adr  = 32'h2000_0000;
        m_wb_dat  = '0;
        m_wb_sel  = '0;
        m_wb_we   = 1'b0;
        m_wb_cyc  = 1'b1;
        rdt_model = '0;
        repeat (3) step();
        #1;
        check("reset cyc", s_wb_cyc, '0);
        check("reset ack", m_wb_ack, 1'b0);
        check("reset err", m_wb_err, 1'b0);
        check("reset rdt", m_wb_rdt, '0);
        m_wb_cyc = 1'b0;
        step();
        rst_n = 1'b1;

        run_txn("rd_s1", 32'h2000_0010, 1'b0, '0, 4'hF, 32'hDEAD_BEEF, 0, -1, 1'b0, 1'b0);
        run_txn("wr_s2", 32'h4000_0004, 1'b1, 32'h1234_5678, 4'hF, 32'h0BAD_F00D, 5, -1, 1'b0, 1'b0);
        run_txn("miss", 32'hE000_0000, 1'b0, '0, 4'hF, 32'h5555_AAAA, 0, -1, 1'b0, 1'b0);
        run_txn("abort", 32'h0000_0100, 1'b0, '0, 4'h3, 32'h7777_7777, 6, 3, 1'b0, 1'b0);

        s_address = {3'd2, 3'd1, 3'd1};
        run_txn("dup", 32'h2000_0000, 1'b0, '0, 4'hF, 32'hCAFE_0001, 3, -1, 1'b1, 1'b0);
        s_address = {3'd2, 3'd1, 3'd0};

        if (TMO_EN) begin
            run_txn("tmo_never", 32'h0000_0040, 1'b0, '0, 4'hF, 32'h1111_2222, 100, -1, 1'b0, 1'b0);
            run_txn("tmo_edge", 32'h0000_0040, 1'b0, '0, 4'hF, 32'h3333_4444, TMO - 1, -1, 1'b0, 1'b0);
        end

        // Reset pulse while waiting on slave1, with that slave acking in the same cycle.
        step();
        m_wb_adr = 32'h2000_0000;
        m_wb_we  = 1'b0;
        m_wb_cyc = 1'b1;
        s_wb_ack = '0;
        step();
        #1;
        check("rst_wait cyc", s_wb_cyc, 3'b010);
        rst_n    = 1'b0;
        s_wb_ack = 3'b010;
        step();
        rst_n    = 1'b1;
        m_wb_cyc = 1'b0;
        s_wb_ack = '0;
        rdt_model = '0;
        #1;
        check("rst_after cyc", s_wb_cyc, '0);
        check("rst_after ack", m_wb_ack, 1'b0);
        check("rst_after err", m_wb_err, 1'b0);
        check("rst_after rdt", m_wb_rdt, rdt_model);
        step();
        #1;
        check("rst_after2 ack", m_wb_ack, 1'b0);
        run_txn("post_rst", 32'h4000_0000, 1'b0, '0, 4'hF, 32'h9876_5432, 2, -1, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [DW-1:0] a;
            int d;
            int ab;
            bit b2b;
            for (int i = 0; i < NS; i++) s_address[i] = AB'($urandom_range(0, 3));
            a = $urandom;
            a[DW-1 -: AB] = AB'($urandom_range(0, 4));
            d = $urandom_range(0, TMO_EN ? 12 : 9);
            ab = -1;
            if ($urandom_range(0, 4) == 0) ab = $urandom_range(0, d);
            b2b = (n != 59) && ($urandom_range(0, 2) == 0);
            run_txn($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(0, 15)), $urandom, d, ab, 1'($urandom_range(0, 1)), b2b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
